dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Shares the single-ported data memory between two requesters: the CPU MEM stage (port C) and the DMA/debug loader (port D).
- Port C has fixed priority.
- A starvation counter forces service of port D.
- A lock mode gives port D back-to-back exclusive access for read-modify-write sequences.
- Read data is registered and returned one cycle after grant.
- The block range-checks addresses and drives the memory's WE/RE/A/WD/pc inputs.

Parameters:
DM_WORDS, 3072, number of 32-bit words in the data memory; legal byte addresses are 0 to DM_WORDS*4-1.
STARVE_LIMIT, 4, consecutive denied cycles of port D before a forced D grant; range 1..15.
CNT_W, 16, width of the stall statistics counter.

Ports:
clk  in  1  clock
reset  in  1  reset
c_req  in  1  port C access request
c_we  in  1  port C write (1) / read (0)
c_addr  in  32  port C byte address, word-aligned
c_wdata  in  32  port C write data
c_pc  in  32  PC of the instruction issuing the port C access
c_gnt  out  1  port C granted this cycle (combinational)
c_rdata  out  32  port C read data (registered)
c_rvalid  out  1  port C read data valid
d_req  in  1  port D access request
d_we  in  1  port D write / read
d_lock  in  1  hold grant to D after the current D access
d_addr  in  32  port D byte address
d_wdata  in  32  port D write data
d_gnt  out  1  port D granted this cycle (combinational)
d_rdata  out  32  port D read data (registered)
d_rvalid  out  1  port D read data valid
addr_err  out  1  one-cycle pulse: the granted access was out of range
dm_we  out  1  memory write enable
dm_re  out  1  memory read enable
dm_a  out  32  memory address
dm_wd  out  32  memory write data
dm_pc  out  32  PC forwarded to memory; 0 for port D accesses
dm_rd  in  32  memory read data (combinational from memory)
stall_cnt  out  CNT_W  cycles in which port C was denied

Behaviour:
- Reset is synchronous, active-high on clk.
- Reset values:
  - state = NORMAL, starve_cnt = 0.
  - c_rvalid, d_rvalid, addr_err = 0.
  - c_rdata, d_rdata = 0.
  - stall_cnt = 0.
- No grant is issued in a cycle where reset is high.
- FSM states:
  - NORMAL: c_req has priority. c_gnt = c_req. d_gnt = d_req & ~c_req.
  - FORCE_D: d_gnt = d_req. c_gnt = 0.
  - LOCK_D: d_gnt = d_req. c_gnt = 0.
- Transitions:
  - NORMAL -> FORCE_D when d_req & ~d_gnt and starve_cnt == STARVE_LIMIT-1.
  - FORCE_D -> LOCK_D on a D grant with d_lock = 1; FORCE_D -> NORMAL on a D grant with d_lock = 0.
  - FORCE_D -> NORMAL when d_req drops.
  - NORMAL -> LOCK_D on a D grant with d_lock = 1.
  - LOCK_D remains while d_lock = 1. LOCK_D -> NORMAL when d_lock = 0, regardless of d_req.
- starve_cnt:
  - Increments each cycle with d_req & ~d_gnt, saturating at STARVE_LIMIT-1.
  - Clears on a D grant or when d_req = 0.
- Memory drive:
  - Outputs are the mux of the granted port's signals.
  - dm_we = grant & we & in_range. dm_re = grant & ~we & in_range.
  - With no grant, all dm_* outputs are 0.
- Range check: in_range = (addr < DM_WORDS*4) and addr[1:0] == 0.
- Out-of-range granted access:
  - Writes are suppressed and reads return 0.
  - addr_err pulses high in the following cycle.
  - c_rvalid / d_rvalid still assert for reads.
- Read latency: a granted read captures dm_rd into c_rdata or d_rdata at the grant edge. The matching rvalid is high for exactly the next cycle.
- Writes produce no rvalid.
- Unchanged rdata registers hold their value.
- A requester whose gnt is 0 must hold its req and fields stable. The arbiter does not latch ungranted requests.
- stall_cnt increments on c_req & ~c_gnt and wraps modulo 2^CNT_W.
- Simultaneous c_req and d_req in NORMAL with starve_cnt below the limit: C wins.
- Reset asserted mid-lock: returns to NORMAL and discards pending rvalid.

Optional Feature:
DM_ARB_TRACE_EN:
- When defined, every granted write prints "time@pc: *addr <= data". The pc field is dm_pc, so port D writes print pc 00000000.
- Every addr_err pulse prints "ARB ERR port addr".
- When undefined, no simulation output is produced and logic is identical.

Test Plan:
1. C read of 0x00000010 holding 0x12345678, D idle -> c_gnt = 1 that cycle; next cycle c_rvalid = 1, c_rdata = 0x12345678; stall_cnt = 0.
2. c_req and d_req held high continuously, STARVE_LIMIT = 4 -> D denied 4 cycles, granted in cycle 5 with c_gnt = 0 (stall_cnt = 1); C resumes in cycle 6.
3. D read 0x20 with d_lock = 1, then D write 0x20 = 0xAABBCCDD with d_lock = 0, c_req high throughout -> both D accesses granted back-to-back, c_gnt = 0 for both, C granted the cycle after.
4. C write to 0x00003000 (out of range) -> dm_we = 0, addr_err = 1 next cycle, memory unchanged; a subsequent C read of 0x00002FFC succeeds.
5. Reset asserted during LOCK_D with a read in flight -> next cycle state = NORMAL, d_rvalid = 0, stall_cnt = 0, c_req granted immediately.
6. C read, misaligned address 0x00000006 -> c_rvalid = 1, c_rdata = 0, addr_err = 1.

Source files
------------

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU port C has fixed priority, port D is protected by a starvation
// counter and can lock back-to-back access. Optional trace output: define DM_ARB_TRACE_EN.
module dm_arbiter #(
  parameter int unsigned DM_WORDS     = 3072,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_req_i,
  input  logic             c_we_i,
  input  logic [31:0]      c_addr_i,
  input  logic [31:0]      c_wdata_i,
  input  logic [31:0]      c_pc_i,
  output logic             c_gnt_o,
  output logic [31:0]      c_rdata_o,
  output logic             c_rvalid_o,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic             d_lock_i,
  input  logic [31:0]      d_addr_i,
  input  logic [31:0]      d_wdata_i,
  output logic             d_gnt_o,
  output logic [31:0]      d_rdata_o,
  output logic             d_rvalid_o,
  output logic             addr_err_o,
  output logic             dm_we_o,
  output logic             dm_re_o,
  output logic [31:0]      dm_a_o,
  output logic [31:0]      dm_wd_o,
  output logic [31:0]      dm_pc_o,
  input  logic [31:0]      dm_rd_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // state   | meaning
  // NORMAL  | C has priority, D served only when C idle
  // FORCE_D | D starved long enough; D owns the memory until served or it drops req
  // LOCK_D  | D holds exclusive access for a read-modify-write sequence
  typedef enum logic [1:0] {NORMAL, FORCE_D, LOCK_D} state_e;

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT - 1);
  localparam logic [31:0] DM_BYTES   = 32'(DM_WORDS * 4);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              c_rvalid_q, d_rvalid_q, addr_err_q;
  logic [31:0]       c_rdata_q, d_rdata_q;
  logic [CNT_W-1:0]  stall_q;

  logic              g_any, g_we, in_range;
  logic [31:0]       g_addr, g_wdata, rd_cap;

  always_comb begin
    c_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
    if (!reset) begin
      if (state_q == NORMAL) begin
        c_gnt_o = c_req_i;
        d_gnt_o = d_req_i & ~c_req_i;
      end else begin
        d_gnt_o = d_req_i;
      end
    end
  end

  always_comb begin
    g_any   = c_gnt_o | d_gnt_o;
    g_we    = 1'b0;
    g_addr  = 32'h0;
    g_wdata = 32'h0;
    if (c_gnt_o) begin
      g_we    = c_we_i;
      g_addr  = c_addr_i;
      g_wdata = c_wdata_i;
    end else if (d_gnt_o) begin
      g_we    = d_we_i;
      g_addr  = d_addr_i;
      g_wdata = d_wdata_i;
    end
    in_range = (g_addr < DM_BYTES) && (g_addr[1:0] == 2'b00);
    rd_cap   = in_range ? dm_rd_i : 32'h0;
  end

  assign dm_we_o = g_any & g_we & in_range;
  assign dm_re_o = g_any & ~g_we & in_range;
  assign dm_a_o  = g_addr;
  assign dm_wd_o = g_wdata;
  assign dm_pc_o = c_gnt_o ? c_pc_i : 32'h0;

  always_comb begin
    if (!d_req_i || d_gnt_o)
      starve_d = 4'd0;
    else if (starve_q != STARVE_MAX)
      starve_d = starve_q + 4'd1;
    else
      starve_d = starve_q;

    state_d = state_q;
    unique case (state_q)
      NORMAL: begin
        if (d_gnt_o && d_lock_i)
          state_d = LOCK_D;
        else if (d_req_i && !d_gnt_o && starve_q == STARVE_MAX)
          state_d = FORCE_D;
      end
      FORCE_D: begin
        if (d_gnt_o)
          state_d = d_lock_i ? LOCK_D : NORMAL;
        else if (!d_req_i)
          state_d = NORMAL;
      end
      LOCK_D:  state_d = d_lock_i ? LOCK_D : NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      starve_q   <= 4'd0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      addr_err_q <= 1'b0;
      c_rdata_q  <= 32'h0;
      d_rdata_q  <= 32'h0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      c_rvalid_q <= c_gnt_o & ~c_we_i;
      d_rvalid_q <= d_gnt_o & ~d_we_i;
      addr_err_q <= g_any & ~in_range;
      if (c_gnt_o && !c_we_i)
        c_rdata_q <= rd_cap;
      if (d_gnt_o && !d_we_i)
        d_rdata_q <= rd_cap;
      if (c_req_i && !c_gnt_o)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign c_rvalid_o  = c_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign c_rdata_o   = c_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign addr_err_o  = addr_err_q;
  assign stall_cnt_o = stall_q;

`ifdef DM_ARB_TRACE_EN
  // Error is reported at the grant edge, i.e. alongside the rising edge of the addr_err pulse.
  always @(posedge clk) begin
    if (!reset && g_any && g_we)
      $display("%0t@%08h: *%08h <= %08h", $time, dm_pc_o, dm_a_o, dm_wd_o);
    if (!reset && g_any && !in_range)
      $display("ARB ERR %s %08h", c_gnt_o ? "C" : "D", g_addr);
  end
`else
  // trace disabled: the arbiter produces no simulation output
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a small behavioural data memory.
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [31:0] c_addr, c_wdata, c_pc, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, addr_err, dm_we, dm_re;
  logic [31:0] c_rdata, d_rdata, dm_a, dm_wd, dm_pc, dm_rd;
  logic [15:0] stall_cnt;

  logic [31:0] mem [0:4095];
  logic        mem_init;
  int          wr_count;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata), .c_pc_i(c_pc),
    .c_gnt_o(c_gnt), .c_rdata_o(c_rdata), .c_rvalid_o(c_rvalid),
    .d_req_i(d_req), .d_we_i(d_we), .d_lock_i(d_lock), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rdata_o(d_rdata), .d_rvalid_o(d_rvalid),
    .addr_err_o(addr_err), .dm_we_o(dm_we), .dm_re_o(dm_re), .dm_a_o(dm_a),
    .dm_wd_o(dm_wd), .dm_pc_o(dm_pc), .dm_rd_i(dm_rd), .stall_cnt_o(stall_cnt)
  );

  assign dm_rd = (dm_a < 32'h3000) ? mem[dm_a[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_init) begin
      mem[12'h004] <= 32'h12345678;
      mem[12'h008] <= 32'h11112222;
      mem[12'hBFF] <= 32'hCAFEF00D;
      wr_count     <= 0;
    end else if (dm_we) begin
      mem[dm_a[13:2]] <= dm_wd;
      wr_count        <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'h0; c_pc = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    step();
    check("rst_no_gnt", c_gnt, 0);
    step();
    mem_init = 1'b0;
    check("rst_c_rvalid", c_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_stall", stall_cnt, 0);

    // 1: plain C read
    reset = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_pc = 32'h100;
    #1;
    check("t1_c_gnt", c_gnt, 1);
    check("t1_d_gnt", d_gnt, 0);
    check("t1_dm_re", dm_re, 1);
    check("t1_dm_a", dm_a, 32'h10);
    check("t1_dm_pc", dm_pc, 32'h100);
    step();
    c_req = 1'b0;
    check("t1_rvalid", c_rvalid, 1);
    check("t1_rdata", c_rdata, 32'h12345678);
    check("t1_stall", stall_cnt, 0);
    step();
    check("t1_rvalid_1cyc", c_rvalid, 0);
    check("t1_rdata_hold", c_rdata, 32'h12345678);

    // 2: starvation forces a D grant on the fifth cycle
    c_req = 1'b1; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_lock = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("t2_c_gnt_%0d", i), c_gnt, 1);
      check($sformatf("t2_d_gnt_%0d", i), d_gnt, 0);
      step();
    end
    #1;
    check("t2_force_d_gnt", d_gnt, 1);
    check("t2_force_c_gnt", c_gnt, 0);
    check("t2_force_pc", dm_pc, 0);
    step();
    check("t2_stall", stall_cnt, 1);
    check("t2_d_rvalid", d_rvalid, 1);
    check("t2_d_rdata", d_rdata, 32'h11112222);
    #1;
    check("t2_c_resume", c_gnt, 1);
    check("t2_d_denied", d_gnt, 0);
    d_req = 1'b0; c_req = 1'b0;
    step();
    step();

    // 3: forced D read with lock, then locked D write, C waits throughout
    c_req = 1'b1; c_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_lock = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    #1;
    check("t3_rd_d_gnt", d_gnt, 1);
    check("t3_rd_c_gnt", c_gnt, 0);
    step();
    d_we = 1'b1; d_wdata = 32'hAABBCCDD; d_lock = 1'b0;
    check("t3_d_rvalid", d_rvalid, 1);
    check("t3_d_rdata", d_rdata, 32'h11112222);
    #1;
    check("t3_wr_d_gnt", d_gnt, 1);
    check("t3_wr_c_gnt", c_gnt, 0);
    check("t3_dm_we", dm_we, 1);
    check("t3_dm_wd", dm_wd, 32'hAABBCCDD);
    step();
    d_req = 1'b0;
    check("t3_wr_no_rvalid", d_rvalid, 0);
    check("t3_stall", stall_cnt, 3);
    check("t3_mem", mem[12'h008], 32'hAABBCCDD);
    #1;
    check("t3_c_after", c_gnt, 1);
    step();
    c_req = 1'b0;
    step();

    // 4: out-of-range C write suppressed, then a legal read at the top word
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h3000; c_wdata = 32'hDEADBEEF; c_pc = 32'h200;
    #1;
    check("t4_c_gnt", c_gnt, 1);
    check("t4_dm_we", dm_we, 0);
    check("t4_dm_re", dm_re, 0);
    step();
    c_req = 1'b0;
    check("t4_addr_err", addr_err, 1);
    check("t4_no_rvalid", c_rvalid, 0);
    check("t4_no_write", wr_count, 1);
    step();
    check("t4_err_pulse", addr_err, 0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h2FFC;
    #1;
    check("t4_top_re", dm_re, 1);
    step();
    c_req = 1'b0;
    check("t4_top_rvalid", c_rvalid, 1);
    check("t4_top_rdata", c_rdata, 32'hCAFEF00D);
    check("t4_top_no_err", addr_err, 0);

    // 6: misaligned read returns zero with an error pulse
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h6;
    #1;
    check("t6_dm_re", dm_re, 0);
    step();
    c_req = 1'b0;
    check("t6_rvalid", c_rvalid, 1);
    check("t6_rdata", c_rdata, 0);
    check("t6_addr_err", addr_err, 1);
    step();

    // 5: reset during LOCK_D with a read in flight
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_lock = 1'b1;
    step();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    #1;
    check("t5_lock_d_gnt", d_gnt, 1);
    check("t5_lock_c_gnt", c_gnt, 0);
    step();
    check("t5_inflight", d_rvalid, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_d_gnt", d_gnt, 0);
    check("t5_rst_c_gnt", c_gnt, 0);
    step();
    check("t5_d_rvalid", d_rvalid, 0);
    check("t5_stall", stall_cnt, 0);
    reset = 1'b0;
    #1;
    check("t5_c_gnt", c_gnt, 1);
    check("t5_d_gnt", d_gnt, 0);
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
